crc_seq_ctrl: RTL



---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_byte_piso.sv | 58 +++++
 rtl/crc_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// Shared encodings and defaults for the CRC engine sequencer.
package crc_pkg;

    localparam int LFSR_WD_DEF = 8;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_WD_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        SHIFT   = 3'd2,
        DRAIN   = 3'd3,
        CAPTURE = 3'd4,
        ABORT   = 3'd5
    } state_e;

    // Counter width able to index every bit of a WD-bit word (at least 1).
    function automatic int idx_wd(input int wd);
        return (wd > 1) ? $clog2(wd) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_byte_piso.sv
`default_nettype none
// Byte parallel-in/serial-out register with bit counter; emits bit 0 first
// and flags the final bit of the current byte.
module crc_byte_piso
    import crc_pkg::*;
#(
    parameter int LFSR_WD = LFSR_WD_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [LFSR_WD-1:0] data_i,
    input  logic               last_i,
    input  logic               shift_i,
    output logic               bit0_o,
    output logic               last_bit_o,
    output logic               last_o
);

    localparam int BC_WD = idx_wd(LFSR_WD);

    logic [LFSR_WD-1:0] shreg_q, shreg_d;
    logic [BC_WD-1:0]   cnt_q,   cnt_d;
    logic               last_q,  last_d;

    // A load wins over a shift so the next byte follows the last bit with no bubble.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
            last_d  = last_i;
        end else if (shift_i) begin
            shreg_d = {1'b0, shreg_q[LFSR_WD-1:1]};
            cnt_d   = cnt_q + BC_WD'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bit0_o     = shreg_q[0];
    assign last_bit_o = (cnt_q == BC_WD'(LFSR_WD - 1));
    assign last_o     = last_q;

endmodule
`default_nettype wire

// File: rtl/crc_seq_ctrl.sv
`default_nettype none
// Sequencer for a bit-serial CRC engine: reseeds it, feeds message bytes LSB
// first, then assembles the serial CRC returned by the engine.
module crc_seq_ctrl
    import crc_pkg::*;
#(
    parameter int LFSR_WD = LFSR_WD_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_WD  = CNT_WD_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [LFSR_WD-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [LFSR_WD-1:0] crc_out,
    output logic               crc_done,
    output logic               err,
    output logic               busy,
    output logic               eng_rst_n,
    output logic               eng_data,
    output logic               eng_active,
    input  logic               eng_crc,
    input  logic               eng_valid
);

    localparam int BC_WD = idx_wd(LFSR_WD);

    state_e             state_q,  state_d;
    logic [CNT_WD-1:0]  to_q,     to_d;
    logic [BC_WD-1:0]   cap_q,    cap_d;
    logic [LFSR_WD-1:0] crc_sh_q, crc_sh_d;
    logic [LFSR_WD-1:0] crc_out_q, crc_out_d;
    logic               done_q,   done_d;
    logic               eng_rst_q;

    logic piso_load, piso_shift, piso_bit0, piso_last_bit, piso_last;

    crc_byte_piso #(
        .LFSR_WD (LFSR_WD)
    ) u_piso (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (piso_load),
        .data_i     (in_data),
        .last_i     (in_last),
        .shift_i    (piso_shift),
        .bit0_o     (piso_bit0),
        .last_bit_o (piso_last_bit),
        .last_o     (piso_last)
    );

    always_comb begin
        state_d    = state_q;
        to_d       = to_q;
        cap_d      = cap_q;
        crc_sh_d   = crc_sh_q;
        crc_out_d  = crc_out_q;
        done_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        in_ready   = 1'b0;
        eng_active = 1'b0;
        eng_data   = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) state_d = SEED;
            end
            SEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    piso_load = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                eng_active = 1'b1;
                eng_data   = piso_bit0;
                piso_shift = 1'b1;
                to_d       = '0;
                if (piso_last_bit) begin
                    if (piso_last) begin
                        state_d = DRAIN;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            piso_load = 1'b1;
                        end else begin
                            err     = 1'b1;
                            state_d = ABORT;
                        end
                    end
                end
            end
            DRAIN: begin
                cap_d = '0;
                // The first Valid cycle already carries CRC bit 0.
                if (eng_valid) begin
                    crc_sh_d[0] = eng_crc;
                    cap_d       = BC_WD'(1);
                    state_d     = CAPTURE;
                end else if (to_q == CNT_WD'(TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = ABORT;
                end else begin
                    to_d = to_q + CNT_WD'(1);
                end
            end
            CAPTURE: begin
                if (eng_valid) begin
                    crc_sh_d[cap_q] = eng_crc;
                    cap_d           = cap_q + BC_WD'(1);
                    if (cap_q == BC_WD'(LFSR_WD - 1)) begin
                        crc_out_d = crc_sh_d;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    err     = 1'b1;
                    state_d = ABORT;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            to_q      <= '0;
            cap_q     <= '0;
            crc_sh_q  <= '0;
            crc_out_q <= '0;
            done_q    <= 1'b0;
            eng_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            cap_q     <= cap_d;
            crc_sh_q  <= crc_sh_d;
            crc_out_q <= crc_out_d;
            done_q    <= done_d;
            // Engine is held in reseed for exactly the SEED and ABORT cycles.
            eng_rst_q <= !((state_d == SEED) || (state_d == ABORT));
        end
    end

    assign crc_out   = crc_out_q;
    assign crc_done  = done_q;
    assign busy      = (state_q != IDLE);
    assign eng_rst_n = eng_rst_q & RST;

endmodule
`default_nettype wire
